// File: rtl/sync_counter_pkg.sv
// rtl/sync_counter_pkg.sv - shared types and defaults for the lab counter set
package sync_counter_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } cnt_state_t;

  // Default prescale: roughly a few count steps per second from a multi-MHz board clock.
  localparam int DEFAULT_TICK_DIV = 4194304;

  // Prescaler register width; a divide-by-one still needs one flop to hold a value.
  function automatic int tick_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - enable-gated prescaler producing a one-cycle count tick
module tick_gen
  import sync_counter_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            PW   = tick_width(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt;

  // Tick only while enabled; a disabled prescaler holds and emits nothing.
  assign tick = en && (cnt == LAST);

  // Prescaler: clear on reset/clear, wrap on tick, otherwise advance only when enabled.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/sync_down_counter.sv
// rtl/sync_down_counter.sv - loadable synchronous down-counter with reload or halt at zero
module sync_down_counter
  import sync_counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int TICK_DIV    = DEFAULT_TICK_DIV,
  parameter bit AUTO_RELOAD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy
);

  cnt_state_t       state;
  logic [WIDTH-1:0] reload;
  logic             tick;
  logic             run_en;

  // The prescaler is frozen in HALT, and a load restarts the step from zero.
  assign run_en = en && (state == RUN);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (run_en),
    .clr (load),
    .tick(tick)
  );

  assign busy = (state == RUN);

  // Count FSM: reset beats load, load beats tick; zero is intercepted before any decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      out    <= '1;
      reload <= '1;
      state  <= RUN;
      tc     <= 1'b0;
    end else if (load) begin
      out    <= load_val;
      reload <= load_val;
      state  <= RUN;
      tc     <= 1'b0;
    end else begin
      tc <= 1'b0;
      case (state)
        RUN: begin
          if (tick) begin
            if (out != '0) begin
              out <= out - WIDTH'(1);
            end else begin
              tc <= 1'b1;
              if (AUTO_RELOAD) begin
                out <= reload;
              end else begin
                state <= HALT;
              end
            end
          end
        end
        HALT: begin
          out <= '0;
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_down_counter.sv
// tb/tb_sync_down_counter.sv - scoreboard bench for sync_down_counter across parameter sets
module tb_sync_down_counter;

  localparam int A = 0;  // TICK_DIV=1, AUTO_RELOAD=1
  localparam int B = 1;  // TICK_DIV=3, AUTO_RELOAD=1
  localparam int C = 2;  // TICK_DIV=1, AUTO_RELOAD=0
  localparam int D = 3;  // TICK_DIV=2, AUTO_RELOAD=1

  typedef struct {
    int         cyc;
    int         dut;
    int         tid;
    logic [3:0] out;
    logic       tc;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_v  [4];
  logic       en_v   [4];
  logic       load_v [4];
  logic [3:0] lv_v   [4];
  logic [3:0] o      [4];
  logic       tc_w   [4];
  logic       busy_w [4];

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sync_down_counter #(.WIDTH(4), .TICK_DIV(1), .AUTO_RELOAD(1'b1)) u_a (
    .clk(clk), .rst(rst_v[A]), .en(en_v[A]), .load(load_v[A]), .load_val(lv_v[A]),
    .out(o[A]), .tc(tc_w[A]), .busy(busy_w[A]));

  sync_down_counter #(.WIDTH(4), .TICK_DIV(3), .AUTO_RELOAD(1'b1)) u_b (
    .clk(clk), .rst(rst_v[B]), .en(en_v[B]), .load(load_v[B]), .load_val(lv_v[B]),
    .out(o[B]), .tc(tc_w[B]), .busy(busy_w[B]));

  sync_down_counter #(.WIDTH(4), .TICK_DIV(1), .AUTO_RELOAD(1'b0)) u_c (
    .clk(clk), .rst(rst_v[C]), .en(en_v[C]), .load(load_v[C]), .load_val(lv_v[C]),
    .out(o[C]), .tc(tc_w[C]), .busy(busy_w[C]));

  sync_down_counter #(.WIDTH(4), .TICK_DIV(2), .AUTO_RELOAD(1'b1)) u_d (
    .clk(clk), .rst(rst_v[D]), .en(en_v[D]), .load(load_v[D]), .load_val(lv_v[D]),
    .out(o[D]), .tc(tc_w[D]), .busy(busy_w[D]));

  // Monitor: at each falling edge, compare every expectation queued for this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || o[e.dut] !== e.out || tc_w[e.dut] !== e.tc || busy_w[e.dut] !== e.busy) begin
        errors++;
        $display("FAIL t%0d dut%0d cyc%0d: got out=%h tc=%b busy=%b, expected out=%h tc=%b busy=%b (for cyc %0d)",
                 e.tid, e.dut, cyc, o[e.dut], tc_w[e.dut], busy_w[e.dut], e.out, e.tc, e.busy, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input int dut, input int tid, input logic [3:0] out,
                            input logic tc, input logic busy);
    exp_t e;
    e.cyc  = cyc;
    e.dut  = dut;
    e.tid  = tid;
    e.out  = out;
    e.tc   = tc;
    e.busy = busy;
    sb.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_v[i]  = 1'b1;
      en_v[i]   = 1'b0;
      load_v[i] = 1'b0;
      lv_v[i]   = 4'h0;
    end

    // Reset state on every instance.
    step();
    for (int i = 0; i < 4; i++) expect_now(i, 0, 4'hF, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 4; i++) expect_now(i, 0, 4'hF, 1'b0, 1'b1);

    // Test 1: free-running from reset, period 16, tc on the wrap back to F.
    rst_v[A] = 1'b0;
    en_v[A]  = 1'b1;
    for (int n = 1; n <= 33; n++) begin
      step();
      expect_now(A, 1, 4'(15 - (n % 16)), (n % 16) == 0, 1'b1);
    end

    // Test 2: TICK_DIV=3 load 5, then freeze mid-step with en low.
    rst_v[B] = 1'b0;
    en_v[B]  = 1'b1;
    load_v[B] = 1'b1;
    lv_v[B]  = 4'h5;
    step(); expect_now(B, 2, 4'h5, 1'b0, 1'b1);
    load_v[B] = 1'b0;
    step(); expect_now(B, 2, 4'h5, 1'b0, 1'b1);
    step(); expect_now(B, 2, 4'h5, 1'b0, 1'b1);
    step(); expect_now(B, 2, 4'h4, 1'b0, 1'b1);
    step(); expect_now(B, 2, 4'h4, 1'b0, 1'b1);
    en_v[B] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step(); expect_now(B, 2, 4'h4, 1'b0, 1'b1);
    end
    en_v[B] = 1'b1;
    step(); expect_now(B, 2, 4'h4, 1'b0, 1'b1);
    step(); expect_now(B, 2, 4'h3, 1'b0, 1'b1);
    step(); expect_now(B, 2, 4'h3, 1'b0, 1'b1);
    step(); expect_now(B, 2, 4'h3, 1'b0, 1'b1);
    step(); expect_now(B, 2, 4'h2, 1'b0, 1'b1);

    // Test 3: halt at zero, then a load restarts the count.
    rst_v[C]  = 1'b0;
    en_v[C]   = 1'b1;
    load_v[C] = 1'b1;
    lv_v[C]   = 4'h2;
    step(); expect_now(C, 3, 4'h2, 1'b0, 1'b1);
    load_v[C] = 1'b0;
    step(); expect_now(C, 3, 4'h1, 1'b0, 1'b1);
    step(); expect_now(C, 3, 4'h0, 1'b0, 1'b1);
    step(); expect_now(C, 3, 4'h0, 1'b1, 1'b0);
    for (int n = 0; n < 12; n++) begin
      step(); expect_now(C, 3, 4'h0, 1'b0, 1'b0);
    end
    load_v[C] = 1'b1;
    lv_v[C]   = 4'h7;
    step(); expect_now(C, 3, 4'h7, 1'b0, 1'b1);
    load_v[C] = 1'b0;
    step(); expect_now(C, 3, 4'h6, 1'b0, 1'b1);

    // Test 4: load coinciding with a tick wins.
    load_v[A] = 1'b1;
    lv_v[A]   = 4'h9;
    step(); expect_now(A, 4, 4'h9, 1'b0, 1'b1);
    lv_v[A]   = 4'h3;
    step(); expect_now(A, 4, 4'h3, 1'b0, 1'b1);
    load_v[A] = 1'b0;
    step(); expect_now(A, 4, 4'h2, 1'b0, 1'b1);

    // Test 5: reset together with load returns reset values.
    load_v[B] = 1'b1;
    lv_v[B]   = 4'h4;
    step(); expect_now(B, 5, 4'h4, 1'b0, 1'b1);
    rst_v[B]  = 1'b1;
    lv_v[B]   = 4'h9;
    step(); expect_now(B, 5, 4'hF, 1'b0, 1'b1);
    rst_v[B]  = 1'b0;
    load_v[B] = 1'b0;
    step(); expect_now(B, 5, 4'hF, 1'b0, 1'b1);

    // Test 6: reload value zero pulses tc every second cycle.
    rst_v[D]  = 1'b0;
    en_v[D]   = 1'b1;
    load_v[D] = 1'b1;
    lv_v[D]   = 4'h0;
    step(); expect_now(D, 6, 4'h0, 1'b0, 1'b1);
    load_v[D] = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      step(); expect_now(D, 6, 4'h0, (n % 2) == 0, 1'b1);
    end

    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
